// File: rtl/serial_tx_pkg.sv
// Shared types and sizing helpers for the LSB-first serial word transmitter.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } tx_state_t;

    localparam int DEF_W   = 8;
    localparam int DEF_GAP = 1;

    // A counter always needs at least one bit, even for a modulus of 1.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// Modulo-MOD up-counter with synchronous clear, enable and a terminal-count wrap flag.
module serial_bit_counter #(
    parameter int MOD   = 8,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    assign wrap = en && (count == WIDTH'(MOD - 1));

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/serial_lsb_word_tx.sv
// Parallel-to-serial transmitter: one W-bit word per handshake, sent LSB first with sof/eof
// markers, followed by GAP idle cycles.
module serial_lsb_word_tx
    import serial_tx_pkg::*;
#(
    parameter int W   = DEF_W,
    parameter int GAP = DEF_GAP
) (
    input  logic         clk,
    input  logic         areset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         x,
    output logic         x_valid,
    output logic         sof,
    output logic         eof,
    output logic         busy
);

    localparam int CNT_W   = clog2_min1(W);
    localparam int GAP_W   = clog2_min1(GAP + 1);
    localparam int GAP_MOD = (GAP > 0) ? GAP : 1;

    tx_state_t    state;
    tx_state_t    state_next;
    logic [W-1:0] shreg;
    logic [CNT_W-1:0] bit_cnt;
    logic         bit_wrap;
    logic [GAP_W-1:0] gap_cnt_unused;
    logic         gap_wrap;
    logic         accept;

    assign accept = in_valid && in_ready;

    serial_bit_counter #(.MOD(W), .WIDTH(CNT_W)) u_bit_cnt (
        .clk    (clk),
        .areset (areset),
        .clr    (accept),
        .en     (state == S_SHIFT),
        .count  (bit_cnt),
        .wrap   (bit_wrap)
    );

    serial_bit_counter #(.MOD(GAP_MOD), .WIDTH(GAP_W)) u_gap_cnt (
        .clk    (clk),
        .areset (areset),
        .clr    (1'b0),
        .en     (state == S_GAP),
        .count  (gap_cnt_unused),
        .wrap   (gap_wrap)
    );

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // An accept always reloads the word; this also covers the eof-cycle accept when GAP == 0.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            shreg <= '0;
        end else if (accept) begin
            shreg <= in_data;
        end else if (state == S_SHIFT) begin
            shreg <= {1'b0, shreg[W-1:1]};
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) state_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (bit_wrap) begin
                    if (GAP > 0)     state_next = S_GAP;
                    else if (accept) state_next = S_SHIFT;
                    else             state_next = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_wrap) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        x        = 1'b0;
        x_valid  = 1'b0;
        sof      = 1'b0;
        eof      = 1'b0;
        busy     = (state != S_IDLE);
        in_ready = (state == S_IDLE);
        if (state == S_SHIFT) begin
            x        = shreg[0];
            x_valid  = 1'b1;
            sof      = (bit_cnt == '0);
            eof      = bit_wrap;
            in_ready = (GAP == 0) && bit_wrap;
        end
    end

endmodule

// File: tb/tb_serial_lsb_word_tx.sv
// Directed bench for serial_lsb_word_tx: one instance with GAP=1, one with GAP=0.
module tb_serial_lsb_word_tx;

    logic       clk = 1'b0;
    logic       areset = 1'b1;

    logic       a_in_valid = 1'b0;
    logic [7:0] a_in_data = 8'h00;
    logic       a_in_ready, a_x, a_x_valid, a_sof, a_eof, a_busy;

    logic       b_in_valid = 1'b0;
    logic [7:0] b_in_data = 8'h00;
    logic       b_in_ready, b_x, b_x_valid, b_sof, b_eof, b_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_lsb_word_tx #(.W(8), .GAP(1)) dut_a (
        .clk      (clk),
        .areset   (areset),
        .in_valid (a_in_valid),
        .in_ready (a_in_ready),
        .in_data  (a_in_data),
        .x        (a_x),
        .x_valid  (a_x_valid),
        .sof      (a_sof),
        .eof      (a_eof),
        .busy     (a_busy)
    );

    serial_lsb_word_tx #(.W(8), .GAP(0)) dut_b (
        .clk      (clk),
        .areset   (areset),
        .in_valid (b_in_valid),
        .in_ready (b_in_ready),
        .in_data  (b_in_data),
        .x        (b_x),
        .x_valid  (b_x_valid),
        .sof      (b_sof),
        .eof      (b_eof),
        .busy     (b_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for in_ready on dut_a, then hand over one word.
    task automatic accept_a(input logic [7:0] word);
        int n = 0;
        while (!a_in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("a_ready_wait", {15'd0, a_in_ready}, 16'd1);
        a_in_valid = 1'b1;
        a_in_data  = word;
        tick();
        a_in_valid = 1'b0;
    endtask

    // Observe one frame on dut_a; also run it through a Mealy two's complementer.
    task automatic frame_a(input string tag, output logic [7:0] got_x, output logic [7:0] got_z);
        logic seen_one = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_xv"},  {15'd0, a_x_valid}, 16'd1);
            chk({tag, "_sof"}, {15'd0, a_sof}, {15'd0, i == 0});
            chk({tag, "_eof"}, {15'd0, a_eof}, {15'd0, i == 7});
            chk({tag, "_rdy"}, {15'd0, a_in_ready}, 16'd0);
            got_x[i] = a_x;
            got_z[i] = a_x ^ seen_one;
            seen_one = seen_one | a_x;
            tick();
        end
    endtask

    logic [7:0]  gx, gz;
    logic [15:0] seq;

    initial begin
        #2;
        chk("rst_x",    {15'd0, a_x}, 16'd0);
        chk("rst_xv",   {15'd0, a_x_valid}, 16'd0);
        chk("rst_sof",  {15'd0, a_sof}, 16'd0);
        chk("rst_eof",  {15'd0, a_eof}, 16'd0);
        chk("rst_busy", {15'd0, a_busy}, 16'd0);
        chk("rst_rdy",  {15'd0, a_in_ready}, 16'd1);
        tick();
        areset = 1'b0;
        tick();

        // Quiet period: nothing moves without in_valid.
        for (int i = 0; i < 20; i++) begin
            chk("idle_xv",   {15'd0, a_x_valid}, 16'd0);
            chk("idle_rdy",  {15'd0, a_in_ready}, 16'd1);
            chk("idle_busy", {15'd0, a_busy}, 16'd0);
            tick();
        end

        // 0x01 then one gap cycle.
        accept_a(8'h01);
        frame_a("w01", gx, gz);
        chk("w01_x", {8'd0, gx}, 16'h0001);
        chk("gap_xv",   {15'd0, a_x_valid}, 16'd0);
        chk("gap_rdy",  {15'd0, a_in_ready}, 16'd0);
        chk("gap_busy", {15'd0, a_busy}, 16'd1);
        tick();
        chk("post_gap_rdy",  {15'd0, a_in_ready}, 16'd1);
        chk("post_gap_busy", {15'd0, a_busy}, 16'd0);

        // Downstream two's complementer view.
        accept_a(8'h05);
        frame_a("w05", gx, gz);
        chk("w05_z", {8'd0, gz}, 16'h00FB);
        accept_a(8'h00);
        frame_a("w00", gx, gz);
        chk("w00_z", {8'd0, gz}, 16'h0000);
        accept_a(8'h80);
        frame_a("w80", gx, gz);
        chk("w80_z", {8'd0, gz}, 16'h0080);

        // Word offered during SHIFT and GAP must wait for in_ready.
        accept_a(8'h3C);
        a_in_valid = 1'b1;
        a_in_data  = 8'h66;
        frame_a("w3c", gx, gz);
        chk("w3c_x", {8'd0, gx}, 16'h003C);
        chk("hold_gap_rdy", {15'd0, a_in_ready}, 16'd0);
        tick();
        chk("hold_idle_rdy", {15'd0, a_in_ready}, 16'd1);
        tick();
        a_in_valid = 1'b0;
        frame_a("w66", gx, gz);
        chk("w66_x", {8'd0, gx}, 16'h0066);
        tick();

        // Asynchronous reset in the middle of 0xFF, then a clean 0x0F.
        accept_a(8'hFF);
        for (int i = 0; i < 4; i++) tick();
        chk("pre_rst_x", {15'd0, a_x}, 16'd1);
        #2;
        areset = 1'b1;
        #1;
        chk("arst_x",    {15'd0, a_x}, 16'd0);
        chk("arst_xv",   {15'd0, a_x_valid}, 16'd0);
        chk("arst_sof",  {15'd0, a_sof}, 16'd0);
        chk("arst_eof",  {15'd0, a_eof}, 16'd0);
        chk("arst_busy", {15'd0, a_busy}, 16'd0);
        chk("arst_rdy",  {15'd0, a_in_ready}, 16'd1);
        areset = 1'b0;
        tick();
        accept_a(8'h0F);
        frame_a("w0f", gx, gz);
        chk("w0f_x", {8'd0, gx}, 16'h000F);
        tick();

        // GAP=0 back-to-back frames 0xA5, 0x3C.
        seq = 16'h3CA5;
        chk("b_rdy", {15'd0, b_in_ready}, 16'd1);
        b_in_valid = 1'b1;
        b_in_data  = 8'hA5;
        tick();
        b_in_data  = 8'h3C;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) b_in_valid = 1'b0;
            chk("b2b_xv",  {15'd0, b_x_valid}, 16'd1);
            chk("b2b_x",   {15'd0, b_x}, {15'd0, seq[i]});
            chk("b2b_sof", {15'd0, b_sof}, {15'd0, (i == 0) || (i == 8)});
            chk("b2b_eof", {15'd0, b_eof}, {15'd0, (i == 7) || (i == 15)});
            chk("b2b_rdy", {15'd0, b_in_ready}, {15'd0, (i == 7) || (i == 15)});
            tick();
        end
        chk("b_end_xv",   {15'd0, b_x_valid}, 16'd0);
        chk("b_end_rdy",  {15'd0, b_in_ready}, 16'd1);
        chk("b_end_busy", {15'd0, b_busy}, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
